// File: rtl/dac_if_pkg.sv
// Shared DAC-side helpers: midscale constant and the per-channel code conversion
// from modulator sample codes to DAC pin data.
package dac_if_pkg;

  localparam int unsigned MaxW        = 32;
  localparam int unsigned DacWDefault = 10;
  localparam logic [DacWDefault-1:0] DAC_MID = {1'b1, {(DacWDefault - 1){1'b0}}};

  function automatic logic [MaxW-1:0] dac_mid(input int unsigned w);
    return MaxW'(1) << (w - 1);
  endfunction

  // Two's complement becomes offset binary by flipping the sign bit of a w-bit code.
  function automatic logic [MaxW-1:0] to_offset_bin(input logic [MaxW-1:0] code,
                                                    input int unsigned w,
                                                    input logic twos);
    logic [MaxW-1:0] r;
    r = code;
    if (twos) r[w-1] = ~r[w-1];
    return r;
  endfunction

  function automatic logic [MaxW-1:0] widen(input logic [MaxW-1:0] code,
                                            input int unsigned in_w,
                                            input int unsigned dac_w);
    return code << (dac_w - in_w);
  endfunction

endpackage

// File: rtl/code_fifo2.sv
// Two-entry FIFO holding paired A/B sample codes between the handshake and the DAC tick.
module code_fifo2
  import dac_if_pkg::*;
#(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o,
  output logic [1:0]       count_o,
  output logic             empty_o,
  output logic             full_o
);

  logic [Width-1:0] entry0_q, entry0_d, entry1_q, entry1_d;
  logic             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == 2'd0);
  assign full_o  = (count_q == 2'd2);
  assign count_o = count_q;
  assign rdata_o = rd_ptr_q ? entry1_q : entry0_q;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      if (wr_ptr_q) entry1_d = wdata_i;
      else          entry0_d = wdata_i;
      wr_ptr_d = ~wr_ptr_q;
    end
    if (do_pop) rd_ptr_d = ~rd_ptr_q;
    if (do_push && !do_pop)      count_d = count_q + 2'd1;
    else if (do_pop && !do_push) count_d = count_q - 2'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      entry0_q <= '0;
      entry1_q <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/dual_dac_writer.sv
// Dual-channel DAC writer: buffers A/B code pairs from the modulator and presents them
// to a parallel DAC at clk_DA/DIV together with a 50% duty DAC latch clock.
module dual_dac_writer
  import dac_if_pkg::*;
#(
  parameter int unsigned DIV       = 4,
  parameter int unsigned IN_W      = 8,
  parameter int unsigned DAC_W     = 10,
  parameter bit          TWOS_COMP = 1'b1
) (
  input  logic             clk_DA,
  input  logic             rst,
  input  logic [IN_W-1:0]  Acode_DA,
  input  logic [IN_W-1:0]  Bcode_DA,
  input  logic             code_valid,
  output logic             code_ready,
  output logic [DAC_W-1:0] Adata_out,
  output logic [DAC_W-1:0] Bdata_out,
  output logic             dac_clk,
  output logic             underrun,
  output logic [15:0]      underrun_cnt
);

  localparam int unsigned    CntW    = $clog2(DIV);
  localparam logic [CntW-1:0] CntLast = CntW'(DIV - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(DIV / 2);
  localparam logic [DAC_W-1:0] Mid    = DAC_W'(dac_mid(DAC_W));

  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              tick;
  logic              dac_clk_q, dac_clk_d;
  logic              ready_q, ready_d;
  logic [DAC_W-1:0]  a_q, a_d, b_q, b_d;
  logic              underrun_q, underrun_d;
  logic [15:0]       underrun_cnt_q, underrun_cnt_d;

  logic              push, pop;
  logic [2*IN_W-1:0] fifo_rdata;
  logic [1:0]        fifo_count, fill_next;
  logic              fifo_empty, fifo_full;
  logic [IN_W-1:0]   a_code, b_code;
  logic [DAC_W-1:0]  a_conv, b_conv;

  assign tick  = (cnt_q == CntLast);
  assign cnt_d = tick ? '0 : cnt_q + CntW'(1);
  // Registering on cnt_d puts the rising edge DIV/2 cycles after the data update.
  assign dac_clk_d = (cnt_d >= CntHalf);

  assign push = code_valid && ready_q && !fifo_full;
  assign pop  = tick && !fifo_empty;

  code_fifo2 #(
    .Width (2 * IN_W)
  ) u_fifo (
    .clk_i   (clk_DA),
    .rst_ni  (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({Acode_DA, Bcode_DA}),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  always_comb begin
    fill_next = fifo_count;
    if (push && !pop)      fill_next = fifo_count + 2'd1;
    else if (pop && !push) fill_next = fifo_count - 2'd1;
  end
  assign ready_d = (fill_next != 2'd2);

  assign {a_code, b_code} = fifo_rdata;
  assign a_conv = DAC_W'(widen(to_offset_bin(MaxW'(a_code), IN_W, TWOS_COMP), IN_W, DAC_W));
  assign b_conv = DAC_W'(widen(to_offset_bin(MaxW'(b_code), IN_W, TWOS_COMP), IN_W, DAC_W));

  always_comb begin
    a_d            = a_q;
    b_d            = b_q;
    underrun_d     = 1'b0;
    underrun_cnt_d = underrun_cnt_q;
    if (tick) begin
      if (!fifo_empty) begin
        a_d = a_conv;
        b_d = b_conv;
      end else begin
        underrun_d = 1'b1;
        if (underrun_cnt_q != 16'hFFFF) underrun_cnt_d = underrun_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_DA or negedge rst) begin
    if (!rst) begin
      cnt_q          <= '0;
      dac_clk_q      <= 1'b0;
      ready_q        <= 1'b0;
      a_q            <= Mid;
      b_q            <= Mid;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= 16'd0;
    end else begin
      cnt_q          <= cnt_d;
      dac_clk_q      <= dac_clk_d;
      ready_q        <= ready_d;
      a_q            <= a_d;
      b_q            <= b_d;
      underrun_q     <= underrun_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  assign code_ready   = ready_q;
  assign Adata_out    = a_q;
  assign Bdata_out    = b_q;
  assign dac_clk      = dac_clk_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = underrun_cnt_q;

endmodule

// File: tb/tb_dual_dac_writer.sv
// Directed bench for dual_dac_writer: a default instance (DIV=4, 10-bit, two's complement)
// and an offset-binary 8-bit instance with DIV=2.
module tb_dual_dac_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, valid;
  logic [7:0] acode, bcode;
  logic       ready, dclk, under;
  logic [9:0] adata, bdata;
  logic [15:0] ucnt;

  logic       rst8, valid8;
  logic [7:0] a8, b8;
  logic       ready8, dclk8, under8;
  logic [7:0] adata8, bdata8;
  logic [15:0] ucnt8;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  dual_dac_writer #(
    .DIV       (4),
    .IN_W      (8),
    .DAC_W     (10),
    .TWOS_COMP (1'b1)
  ) u_dut (
    .clk_DA       (clk),
    .rst          (rst),
    .Acode_DA     (acode),
    .Bcode_DA     (bcode),
    .code_valid   (valid),
    .code_ready   (ready),
    .Adata_out    (adata),
    .Bdata_out    (bdata),
    .dac_clk      (dclk),
    .underrun     (under),
    .underrun_cnt (ucnt)
  );

  dual_dac_writer #(
    .DIV       (2),
    .IN_W      (8),
    .DAC_W     (8),
    .TWOS_COMP (1'b0)
  ) u_dut8 (
    .clk_DA       (clk),
    .rst          (rst8),
    .Acode_DA     (a8),
    .Bcode_DA     (b8),
    .code_valid   (valid8),
    .code_ready   (ready8),
    .Adata_out    (adata8),
    .Bdata_out    (bdata8),
    .dac_clk      (dclk8),
    .underrun     (under8),
    .underrun_cnt (ucnt8)
  );

  function automatic logic [9:0] conv10(input logic [7:0] c);
    return {~c[7], c[6:0], 2'b00};
  endfunction

  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    valid = 1'b0;
    rst   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0; valid = 1'b1; acode = 8'h11; bcode = 8'h22;
    repeat (5) @(negedge clk);
    n_tests++;
    if (adata !== 10'h200) begin
      n_fail++; $display("FAIL reset_adata: got %h want %h", adata, 10'h200);
    end
    n_tests++;
    if (bdata !== 10'h200) begin
      n_fail++; $display("FAIL reset_bdata: got %h want %h", bdata, 10'h200);
    end
    n_tests++;
    if (dclk !== 1'b0 || ready !== 1'b0 || under !== 1'b0 || ucnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got clk=%b rdy=%b und=%b cnt=%h want 0 0 0 0",
               dclk, ready, under, ucnt);
    end
    valid = 1'b0;
    rst   = 1'b1;
    cyc   = 0;
    step();
    n_tests++;
    if (ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready_rise: got %b want 1", ready);
    end
    repeat (3) step();
    n_tests++;
    if (under !== 1'b1 || ucnt !== 16'd1 || adata !== 10'h200) begin
      n_fail++;
      $display("FAIL reset_empty: got und=%b cnt=%h a=%h want 1 0001 200", under, ucnt, adata);
    end
  endtask

  task automatic test_single_pair();
    do_reset();
    step();
    acode = 8'h7F; bcode = 8'h80; valid = 1'b1;
    step();
    valid = 1'b0;
    step();
    n_tests++;
    if (adata !== 10'h200) begin
      n_fail++; $display("FAIL single_pre_tick: got %h want %h", adata, 10'h200);
    end
    step();
    n_tests++;
    if (adata !== 10'h3FC || bdata !== 10'h000) begin
      n_fail++; $display("FAIL single_data: got %h/%h want 3fc/000", adata, bdata);
    end
    n_tests++;
    if (dclk !== 1'b0 || under !== 1'b0) begin
      n_fail++; $display("FAIL single_tick_ctrl: got clk=%b und=%b want 0 0", dclk, under);
    end
    step();
    n_tests++;
    if (dclk !== 1'b0) begin
      n_fail++; $display("FAIL single_dclk_low: got %b want 0", dclk);
    end
    step();
    n_tests++;
    if (dclk !== 1'b1) begin
      n_fail++; $display("FAIL single_dclk_rise: got %b want 1", dclk);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] q[$];
    logic [7:0] v, exp_v, exp_b;
    logic       ready_m, push_m, popped;
    do_reset();
    ready_m = 1'b0;
    v = 8'h00;
    for (int i = 0; i < 40; i++) begin
      acode = v; bcode = v + 8'h40; valid = 1'b1;
      push_m = ready_m;
      step();
      popped = 1'b0;
      exp_v  = 8'h00;
      if ((cyc % 4 == 0) && (q.size() > 0)) begin
        exp_v  = q.pop_front();
        popped = 1'b1;
      end
      if (push_m) begin
        q.push_back(v);
        v = v + 8'h01;
      end
      ready_m = (q.size() < 2);
      n_tests++;
      if (ready !== ready_m) begin
        n_fail++; $display("FAIL b2b_ready cyc %0d: got %b want %b", cyc, ready, ready_m);
      end
      if (popped) begin
        exp_b = exp_v + 8'h40;
        n_tests++;
        if (adata !== conv10(exp_v) || bdata !== conv10(exp_b)) begin
          n_fail++;
          $display("FAIL b2b_data cyc %0d: got %h/%h want %h/%h",
                   cyc, adata, bdata, conv10(exp_v), conv10(exp_b));
        end
      end
    end
    valid = 1'b0;
  endtask

  task automatic test_underrun();
    int pulses;
    do_reset();
    step();
    acode = 8'h05; bcode = 8'hFB; valid = 1'b1;
    step();
    valid = 1'b0;
    repeat (2) step();
    n_tests++;
    if (adata !== 10'h214 || bdata !== 10'h1EC || under !== 1'b0) begin
      n_fail++; $display("FAIL under_data: got %h/%h und=%b want 214/1ec 0", adata, bdata, under);
    end
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      pulses += int'(under);
      n_tests++;
      if (under !== (cyc % 4 == 0)) begin
        n_fail++; $display("FAIL under_pulse cyc %0d: got %b want %b", cyc, under, cyc % 4 == 0);
      end
    end
    n_tests++;
    if (ucnt !== 16'd3 || pulses != 3) begin
      n_fail++; $display("FAIL under_count: got cnt=%0d pulses=%0d want 3 3", ucnt, pulses);
    end
    n_tests++;
    if (adata !== 10'h214 || bdata !== 10'h1EC) begin
      n_fail++; $display("FAIL under_hold: got %h/%h want 214/1ec", adata, bdata);
    end
  endtask

  // Follows test_underrun directly: buffer empty, underrun_cnt == 3, cyc == 16.
  task automatic test_async_reset();
    acode = 8'h10; bcode = 8'h11; valid = 1'b1;
    step();
    acode = 8'h20; bcode = 8'h21;
    step();
    valid = 1'b0;
    n_tests++;
    if (ready !== 1'b0 || dclk !== 1'b1) begin
      n_fail++; $display("FAIL arst_full: got rdy=%b clk=%b want 0 1", ready, dclk);
    end
    #1 rst = 1'b0;
    #1;
    n_tests++;
    if (adata !== 10'h200 || bdata !== 10'h200) begin
      n_fail++; $display("FAIL arst_mid: got %h/%h want 200/200", adata, bdata);
    end
    n_tests++;
    if (ucnt !== 16'd0 || ready !== 1'b0 || dclk !== 1'b0) begin
      n_fail++; $display("FAIL arst_ctrl: got cnt=%h rdy=%b clk=%b want 0 0 0", ucnt, ready, dclk);
    end
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    repeat (4) step();
    n_tests++;
    if (under !== 1'b1 || ucnt !== 16'd1 || adata !== 10'h200) begin
      n_fail++;
      $display("FAIL arst_empty: got und=%b cnt=%h a=%h want 1 0001 200", under, ucnt, adata);
    end
  endtask

  task automatic test_offset_bin();
    rst = 1'b0;
    n_tests++;
    if (adata8 !== 8'h80 || bdata8 !== 8'h80) begin
      n_fail++; $display("FAIL ob_reset: got %h/%h want 80/80", adata8, bdata8);
    end
    rst8 = 1'b1;
    cyc  = 0;
    step();
    a8 = 8'h00; b8 = 8'hFF; valid8 = 1'b1;
    step();
    valid8 = 1'b0;
    repeat (2) step();
    n_tests++;
    if (adata8 !== 8'h00 || bdata8 !== 8'hFF) begin
      n_fail++; $display("FAIL ob_pair1: got %h/%h want 00/ff", adata8, bdata8);
    end
    a8 = 8'hFF; b8 = 8'h5A; valid8 = 1'b1;
    step();
    valid8 = 1'b0;
    step();
    n_tests++;
    if (adata8 !== 8'hFF || bdata8 !== 8'h5A || dclk8 !== 1'b0) begin
      n_fail++; $display("FAIL ob_pair2: got %h/%h clk=%b want ff/5a 0", adata8, bdata8, dclk8);
    end
    step();
    n_tests++;
    if (dclk8 !== 1'b1 || ucnt8 !== 16'd1) begin
      n_fail++; $display("FAIL ob_ctrl: got clk=%b cnt=%0d want 1 1", dclk8, ucnt8);
    end
  endtask

  task automatic test_saturation();
    force u_dut8.underrun_cnt_q = 16'hFFFE;
    step();
    release u_dut8.underrun_cnt_q;
    repeat (6) step();
    n_tests++;
    if (ucnt8 !== 16'hFFFF) begin
      n_fail++; $display("FAIL sat_count: got %h want ffff", ucnt8);
    end
    n_tests++;
    if (under8 !== 1'b1) begin
      n_fail++; $display("FAIL sat_pulse: got %b want 1", under8);
    end
  endtask

  initial begin
    rst = 1'b0; valid = 1'b0; acode = 8'h00; bcode = 8'h00;
    rst8 = 1'b0; valid8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    test_reset();
    test_single_pair();
    test_back_to_back();
    test_underrun();
    test_async_reset();
    test_offset_bin();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
